set_bit_iterator: RTL and testbench
===================================

# set_bit_iterator

Sequential successor to the combinational first/second-set-bit finders. It accepts a WIDTH-bit vector and emits every set bit, one per output handshake, in a selectable direction (LSB-first or MSB-first). Each beat carries the bit's one-hot, index, ordinal rank and a last flag. It sits between a request-vector producer (arbiter, pending-interrupt register, free-list bitmap) and a consumer that services one entry at a time.

## Interface
- WIDTH, 16, vector width; legal range ≥ 2
- IDX_W, $clog2(WIDTH), width of the index output (derived)
- CNT_W, $clog2(WIDTH+1), width of the count and rank outputs (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- load_valid_i  in  1  load request
- load_ready_o  out  1  block is idle and can accept a load
- vec_i  in  WIDTH  vector to iterate; sampled at load handshake
- dir_i  in  1  scan direction, sampled at load; 0 = LSB-first, 1 = MSB-first
- abort_i  in  1  flush the current scan
- out_valid_o  out  1  a beat is presented
- out_ready_i  in  1  consumer accepts the beat
- out_onehot_o  out  WIDTH  one-hot of the current set bit
- out_idx_o  out  IDX_W  binary index of the current set bit
- out_rank_o  out  CNT_W  0-based ordinal of the beat within the scan
- out_last_o  out  1  current beat is the final set bit
- count_o  out  CNT_W  popcount of the loaded vector, held from load until the next load
- done_o  out  1  one-cycle pulse marking the end of a scan

## Operation
- States: IDLE, SCAN, DONE.
- IDLE
  - load_ready_o=1.
  - A load handshake (load_valid_i & load_ready_o) registers vec_i into rem, dir_i into dir, and popcount(vec_i) into count_o, and clears rank.
  - Next state is SCAN if vec_i≠0, otherwise DONE.
- SCAN
  - out_valid_o=1.
  - out_onehot_o is the first set bit of rem in direction dir.
  - out_idx_o is its binary index.
  - out_last_o=1 when rem has exactly one bit set.
  - On an output handshake, the presented bit is cleared from rem and rank increments.
  - If out_last_o was set on that handshake, next state is DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Outputs are held stable while out_valid_o=1 and out_ready_i=0.
- abort_i has priority over the output handshake. In SCAN or DONE it forces IDLE next cycle and clears rem. No done_o pulse is produced. abort_i in IDLE is ignored.
- Outside SCAN, out_onehot_o, out_idx_o, out_rank_o and out_last_o are driven 0.

## Timing
- Reset values:
  - State is IDLE, so load_ready_o=1.
  - out_valid_o=0, done_o=0.
  - count_o, rank, rem and dir are 0.
  - All data outputs are 0.
- Load accepted at cycle T → out_valid_o=1 at T+1.
- Beat-to-beat: one beat per cycle with out_ready_i held high.
  - A vector with k set bits has its final handshake at T+k.
  - done_o is high at T+k+1.
  - load_ready_o is high again at T+k+2.
- Zero vector loaded at T: no beats; done_o=1 at T+1; IDLE at T+2.
- A load is never accepted in SCAN or DONE, because load_ready_o=0.
- abort_i asserted at cycle A (SCAN or DONE) → IDLE at A+1. An output handshake in cycle A is not counted.
- reset mid-scan has the same effect as abort, and additionally clears count_o.

## Structure
- Package set_bit_iter_pkg holds:
  - the state enum (IDLE/SCAN/DONE);
  - direction localparams DIR_LSB=0 and DIR_MSB=1.
- Sub-module find_first_set #(WIDTH): combinational, with a dir input.
  - Outputs the one-hot and binary index of the lowest set bit (dir=0) or the highest set bit (dir=1).
  - Zero input gives zero outputs.
- Popcount and the "exactly one bit set" check are inline functions in the package.

## Test plan
- LSB-first, WIDTH=16, vec_i=16'h0A50, dir_i=0, out_ready_i=1.
  - Beats: idx 4,6,9,11 with rank 0..3.
  - out_last_o on idx 11; count_o=4.
  - done_o at load+5.
- MSB-first: same vector with dir_i=1.
  - Beats: idx 11,9,6,4; out_onehot_o on the first beat is 16'h0800; out_last_o on idx 4.
- Backpressure: vec_i=16'h8001, out_ready_i toggled 0/1 randomly.
  - Each beat holds all outputs stable until accepted.
  - Exactly 2 beats are produced (idx 0, then 15).
- Zero vector: vec_i=0.
  - out_valid_o never rises; count_o=0; done_o pulses at load+1.
- Abort: vec_i=16'hFFFF, abort_i asserted after 3 accepted beats.
  - IDLE next cycle; no done_o pulse.
  - An immediate reload of 16'h0002 yields a single beat, idx 1, rank 0, last=1.
- Full vector: vec_i=16'hFFFF.
  - 16 consecutive beats, ranks 0..15; out_last_o only at rank 15; count_o=16.
  - A reset asserted mid-scan returns all outputs to their reset values on the next cycle.

Source files
------------

// File: rtl/set_bit_iterator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : set_bit_iter_pkg
// Description : Shared types and helpers for the set-bit iterator:
//               FSM state encoding, scan-direction codes, popcount and
//               exactly-one-bit-set helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package set_bit_iter_pkg;

    // Widest vector the helper functions accept. Callers zero-extend.
    localparam int MAX_W = 1024;

    localparam logic DIR_LSB = 1'b0;
    localparam logic DIR_MSB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned popcount(input logic [MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    // Clearing the lowest set bit leaves zero only when one bit was set.
    function automatic logic is_onehot(input logic [MAX_W-1:0] v);
        return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/set_bit_iterator_if.sv
`default_nettype none
// ============================================================================
// Module      : set_bit_iterator_if
// Description : Load and output handshake bundle of the set-bit iterator.
//               slave  - iterator side (accepts loads, presents beats)
//               master - producer/consumer side
//               Signals: load_valid_i/load_ready_o/vec_i/dir_i (load),
//               abort_i (flush), out_valid_o/out_ready_i/out_onehot_o/
//               out_idx_o/out_rank_o/out_last_o (beats), count_o, done_o.
// Revision    : 1.0 - initial release
// ============================================================================
interface set_bit_iterator_if #(
    parameter int WIDTH = 16
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             load_valid_i;
    logic             load_ready_o;
    logic [WIDTH-1:0] vec_i;
    logic             dir_i;
    logic             abort_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] out_onehot_o;
    logic [IDX_W-1:0] out_idx_o;
    logic [CNT_W-1:0] out_rank_o;
    logic             out_last_o;
    logic [CNT_W-1:0] count_o;
    logic             done_o;

    modport slave (
        input  load_valid_i, vec_i, dir_i, abort_i, out_ready_i,
        output load_ready_o, out_valid_o, out_onehot_o, out_idx_o,
               out_rank_o, out_last_o, count_o, done_o
    );

    modport master (
        output load_valid_i, vec_i, dir_i, abort_i, out_ready_i,
        input  load_ready_o, out_valid_o, out_onehot_o, out_idx_o,
               out_rank_o, out_last_o, count_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/set_bit_iterator_find_first_set.sv
`default_nettype none
// ============================================================================
// Module      : find_first_set
// Description : Combinational first-set-bit finder with selectable
//               direction. i_dir=0 picks the lowest set bit, i_dir=1 the
//               highest. Zero input yields zero one-hot and zero index.
//               Ports: i_vec, i_dir -> o_onehot, o_idx.
// Revision    : 1.0 - initial release
// ============================================================================
module find_first_set
    import set_bit_iter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  wire logic [WIDTH-1:0] i_vec,
    input  wire logic             i_dir,
    output logic      [WIDTH-1:0] o_onehot,
    output logic      [IDX_W-1:0] o_idx
);

    logic [WIDTH-1:0] w_vec_rev;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_pick;
    logic [WIDTH-1:0] w_pick_rev;

    // MSB-first search reuses the lowest-bit isolator on a bit-reversed copy.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
        assign w_vec_rev[gi]  = i_vec[WIDTH-1-gi];
        assign w_pick_rev[gi] = w_pick[WIDTH-1-gi];
    end

    assign w_src    = (i_dir == DIR_MSB) ? w_vec_rev : i_vec;
    // Two's-complement trick: x & -x isolates the lowest set bit.
    assign w_pick   = w_src & (~w_src + WIDTH'(1));
    assign o_onehot = (i_dir == DIR_MSB) ? w_pick_rev : w_pick;

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (o_onehot[i]) begin
                o_idx = o_idx | IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/set_bit_iterator.sv
`default_nettype none
// ============================================================================
// Module      : set_bit_iterator
// Description : Sequential set-bit iterator. Loads a WIDTH-bit vector and
//               presents every set bit, one per output handshake, LSB-first
//               or MSB-first. Each beat carries one-hot, index, rank and a
//               last flag; done pulses for one cycle at end of scan.
//               Ports: clk, reset (sync, active-high), bus (slave modport of
//               set_bit_iterator_if).
// Revision    : 1.0 - initial release
// ============================================================================
module set_bit_iterator
    import set_bit_iter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    set_bit_iterator_if.slave  bus
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_rem;
    logic             r_dir;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_rank;

    logic [WIDTH-1:0] w_onehot;
    logic [IDX_W-1:0] w_idx;
    logic             w_last;
    logic             w_load_ready;
    logic             w_out_valid;
    logic             w_done;
    logic             w_load_hs;
    logic             w_out_hs;

    find_first_set #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_ffs (
        .i_vec    (r_rem),
        .i_dir    (r_dir),
        .o_onehot (w_onehot),
        .o_idx    (w_idx)
    );

    assign w_last    = is_onehot(MAX_W'(r_rem));
    assign w_load_hs = w_load_ready & bus.load_valid_i;
    // Abort wins over a concurrent output handshake.
    assign w_out_hs  = w_out_valid & bus.out_ready_i & ~bus.abort_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_ready = 1'b0;
        w_out_valid  = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                w_load_ready = 1'b1;
                if (bus.load_valid_i) begin
                    w_state_nxt = (bus.vec_i != '0) ? SCAN : DONE;
                end
            end
            SCAN: begin
                w_out_valid = 1'b1;
                if (bus.abort_i) begin
                    w_state_nxt = IDLE;
                end else if (bus.out_ready_i && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                // An abort landing on the DONE cycle suppresses the pulse.
                w_done      = ~bus.abort_i;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rem   <= '0;
            r_dir   <= DIR_LSB;
            r_count <= '0;
            r_rank  <= '0;
        end else begin
            if (w_load_hs) begin
                r_rem   <= bus.vec_i;
                r_dir   <= bus.dir_i;
                r_count <= CNT_W'(popcount(MAX_W'(bus.vec_i)));
                r_rank  <= '0;
            end else if (bus.abort_i && (r_state != IDLE)) begin
                r_rem <= '0;
            end else if (w_out_hs) begin
                r_rem  <= r_rem & ~w_onehot;
                r_rank <= r_rank + CNT_W'(1);
            end
        end
    end

    assign bus.load_ready_o = w_load_ready;
    assign bus.out_valid_o  = w_out_valid;
    assign bus.done_o       = w_done;
    assign bus.count_o      = r_count;
    assign bus.out_onehot_o = w_out_valid ? w_onehot : '0;
    assign bus.out_idx_o    = w_out_valid ? w_idx    : '0;
    assign bus.out_rank_o   = w_out_valid ? r_rank   : '0;
    assign bus.out_last_o   = w_out_valid & w_last;

endmodule
`default_nettype wire

// File: tb/tb_set_bit_iterator.sv
`default_nettype none
// ============================================================================
// Module      : tb_set_bit_iterator
// Description : Directed self-checking bench for set_bit_iterator (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_set_bit_iterator;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    set_bit_iterator_if #(.WIDTH(16)) bus ();

    set_bit_iterator #(.WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents a load at a negedge; the handshake happens on the next posedge.
    task automatic do_load(input logic [15:0] v, input logic d);
        bus.load_valid_i = 1'b1;
        bus.vec_i        = v;
        bus.dir_i        = d;
        @(negedge clk);
        bus.load_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (bus.load_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_load_ready: got %0b expected 1", bus.load_ready_o); end
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid_o); end
        n_cmp++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", bus.done_o); end
        n_cmp++; if (bus.count_o !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count_o); end
        n_cmp++; if ({bus.out_onehot_o, bus.out_idx_o, bus.out_rank_o, bus.out_last_o} !== 26'd0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", {bus.out_onehot_o, bus.out_idx_o, bus.out_rank_o, bus.out_last_o}); end
    endtask

    task automatic test_lsb_first();
        logic [3:0] exp_idx [4] = '{4'd4, 4'd6, 4'd9, 4'd11};
        bus.out_ready_i = 1'b1;
        do_load(16'h0A50, 1'b0);
        for (int b = 0; b < 4; b++) begin
            n_cmp++; if (bus.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL lsb_valid beat %0d: got %0b expected 1", b, bus.out_valid_o); end
            n_cmp++; if (bus.out_idx_o !== exp_idx[b]) begin n_fail++; $display("FAIL lsb_idx beat %0d: got %0d expected %0d", b, bus.out_idx_o, exp_idx[b]); end
            n_cmp++; if (bus.out_onehot_o !== (16'h1 << exp_idx[b])) begin n_fail++; $display("FAIL lsb_onehot beat %0d: got %0h expected %0h", b, bus.out_onehot_o, 16'h1 << exp_idx[b]); end
            n_cmp++; if (bus.out_rank_o !== 5'(b)) begin n_fail++; $display("FAIL lsb_rank beat %0d: got %0d expected %0d", b, bus.out_rank_o, b); end
            n_cmp++; if (bus.out_last_o !== (b == 3)) begin n_fail++; $display("FAIL lsb_last beat %0d: got %0b expected %0b", b, bus.out_last_o, b == 3); end
            n_cmp++; if (bus.count_o !== 5'd4) begin n_fail++; $display("FAIL lsb_count beat %0d: got %0d expected 4", b, bus.count_o); end
            @(negedge clk);
        end
        n_cmp++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL lsb_done: got %0b expected 1", bus.done_o); end
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL lsb_valid_after: got %0b expected 0", bus.out_valid_o); end
        @(negedge clk);
        n_cmp++; if (bus.load_ready_o !== 1'b1 || bus.done_o !== 1'b0) begin n_fail++; $display("FAIL lsb_idle: got ready=%0b done=%0b expected ready=1 done=0", bus.load_ready_o, bus.done_o); end
    endtask

    task automatic test_msb_first();
        logic [3:0] exp_idx [4] = '{4'd11, 4'd9, 4'd6, 4'd4};
        bus.out_ready_i = 1'b1;
        do_load(16'h0A50, 1'b1);
        n_cmp++; if (bus.out_onehot_o !== 16'h0800) begin n_fail++; $display("FAIL msb_first_onehot: got %0h expected 0800", bus.out_onehot_o); end
        for (int b = 0; b < 4; b++) begin
            n_cmp++; if (bus.out_idx_o !== exp_idx[b]) begin n_fail++; $display("FAIL msb_idx beat %0d: got %0d expected %0d", b, bus.out_idx_o, exp_idx[b]); end
            n_cmp++; if (bus.out_rank_o !== 5'(b)) begin n_fail++; $display("FAIL msb_rank beat %0d: got %0d expected %0d", b, bus.out_rank_o, b); end
            n_cmp++; if (bus.out_last_o !== (b == 3)) begin n_fail++; $display("FAIL msb_last beat %0d: got %0b expected %0b", b, bus.out_last_o, b == 3); end
            @(negedge clk);
        end
        n_cmp++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL msb_done: got %0b expected 1", bus.done_o); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [3:0]  exp_idx [2] = '{4'd0, 4'd15};
        int          b;
        int          held;
        int          cyc;
        logic        seen_done;
        logic        rdy;
        b = 0; held = 0; cyc = 0; seen_done = 1'b0;
        bus.out_ready_i = 1'b0;
        do_load(16'h8001, 1'b0);
        while (!seen_done && cyc < 200) begin
            if (bus.done_o) seen_done = 1'b1;
            rdy = 1'b0;
            if (bus.out_valid_o) begin
                if (b < 2) begin
                    n_cmp++; if (bus.out_idx_o !== exp_idx[b] || bus.out_onehot_o !== (16'h1 << exp_idx[b]) || bus.out_rank_o !== 5'(b) || bus.out_last_o !== (b == 1)) begin
                        n_fail++; $display("FAIL bp_beat %0d hold %0d: got idx=%0d oh=%0h rank=%0d last=%0b expected idx=%0d rank=%0d last=%0b", b, held, bus.out_idx_o, bus.out_onehot_o, bus.out_rank_o, bus.out_last_o, exp_idx[b], b, b == 1);
                    end
                end else begin
                    n_cmp++; n_fail++; $display("FAIL bp_extra_beat: got beat %0d expected at most 2", b);
                end
                // First presentation of each beat is always stalled.
                rdy = (held > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            bus.out_ready_i = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) begin b++; held = 0; end else held++;
        end
        n_cmp++; if (b !== 2) begin n_fail++; $display("FAIL bp_beat_count: got %0d expected 2", b); end
        n_cmp++; if (seen_done !== 1'b1) begin n_fail++; $display("FAIL bp_done_seen: got %0b expected 1", seen_done); end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero_vector();
        bus.out_ready_i = 1'b1;
        do_load(16'h0000, 1'b0);
        n_cmp++; if (bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL zero_valid: got %0b expected 0", bus.out_valid_o); end
        n_cmp++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %0b expected 1", bus.done_o); end
        n_cmp++; if (bus.count_o !== 5'd0) begin n_fail++; $display("FAIL zero_count: got %0d expected 0", bus.count_o); end
        @(negedge clk);
        n_cmp++; if (bus.load_ready_o !== 1'b1 || bus.done_o !== 1'b0 || bus.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got ready=%0b done=%0b valid=%0b expected 1 0 0", bus.load_ready_o, bus.done_o, bus.out_valid_o); end
    endtask

    task automatic test_abort();
        bus.out_ready_i = 1'b1;
        do_load(16'hFFFF, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.out_rank_o !== 5'd3 || bus.out_idx_o !== 4'd3) begin n_fail++; $display("FAIL abort_pre: got rank=%0d idx=%0d expected 3 3", bus.out_rank_o, bus.out_idx_o); end
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        n_cmp++; if (bus.load_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.done_o !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got ready=%0b valid=%0b done=%0b expected 1 0 0", bus.load_ready_o, bus.out_valid_o, bus.done_o); end
        n_cmp++; if (bus.count_o !== 5'd16) begin n_fail++; $display("FAIL abort_count_held: got %0d expected 16", bus.count_o); end
        do_load(16'h0002, 1'b0);
        n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.out_idx_o !== 4'd1 || bus.out_rank_o !== 5'd0 || bus.out_last_o !== 1'b1 || bus.out_onehot_o !== 16'h0002) begin
            n_fail++; $display("FAIL abort_reload_beat: got v=%0b idx=%0d rank=%0d last=%0b oh=%0h expected 1 1 0 1 0002", bus.out_valid_o, bus.out_idx_o, bus.out_rank_o, bus.out_last_o, bus.out_onehot_o);
        end
        n_cmp++; if (bus.count_o !== 5'd1) begin n_fail++; $display("FAIL abort_reload_count: got %0d expected 1", bus.count_o); end
        @(negedge clk);
        n_cmp++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL abort_reload_done: got %0b expected 1", bus.done_o); end
        @(negedge clk);
    endtask

    task automatic test_full_and_reset();
        bus.out_ready_i = 1'b1;
        do_load(16'hFFFF, 1'b0);
        for (int b = 0; b < 16; b++) begin
            n_cmp++; if (bus.out_valid_o !== 1'b1 || bus.out_idx_o !== 4'(b) || bus.out_rank_o !== 5'(b) || bus.out_last_o !== (b == 15)) begin
                n_fail++; $display("FAIL full_beat %0d: got v=%0b idx=%0d rank=%0d last=%0b expected 1 %0d %0d %0b", b, bus.out_valid_o, bus.out_idx_o, bus.out_rank_o, bus.out_last_o, b, b, b == 15);
            end
            @(negedge clk);
        end
        n_cmp++; if (bus.count_o !== 5'd16) begin n_fail++; $display("FAIL full_count: got %0d expected 16", bus.count_o); end
        n_cmp++; if (bus.done_o !== 1'b1) begin n_fail++; $display("FAIL full_done: got %0b expected 1", bus.done_o); end
        @(negedge clk);
        do_load(16'hFFFF, 1'b1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (bus.load_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.done_o !== 1'b0 || bus.count_o !== 5'd0) begin
            n_fail++; $display("FAIL midreset_ctrl: got ready=%0b valid=%0b done=%0b count=%0d expected 1 0 0 0", bus.load_ready_o, bus.out_valid_o, bus.done_o, bus.count_o);
        end
        n_cmp++; if ({bus.out_onehot_o, bus.out_idx_o, bus.out_rank_o, bus.out_last_o} !== 26'd0) begin n_fail++; $display("FAIL midreset_data: got %0h expected 0", {bus.out_onehot_o, bus.out_idx_o, bus.out_rank_o, bus.out_last_o}); end
    endtask

    initial begin
        n_cmp            = 0;
        n_fail           = 0;
        reset            = 1'b1;
        bus.load_valid_i = 1'b0;
        bus.vec_i        = '0;
        bus.dir_i        = 1'b0;
        bus.abort_i      = 1'b0;
        bus.out_ready_i  = 1'b0;
        @(negedge clk);
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_backpressure();
        test_zero_vector();
        test_abort();
        test_full_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
